// File: rtl/switch_conditioner.sv
// Conditions the four raw Go Board buttons into debounced levels, one-cycle
// move strobes with hold-to-repeat, and qualified start/reset combo strobes.

module switch_lane #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 3750000,
  parameter int TW              = 25
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Raw,
  input  logic i_Hold,
  output logic o_Level,
  output logic o_Pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rpt_state_t;

  logic [1:0]    sync_pipe;
  logic [DW-1:0] db_cnt;
  logic          level_d;
  rpt_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pulse_d;
  logic          rise, fall;

  assign rise = o_Level & ~level_d;
  assign fall = ~o_Level & level_d;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync_pipe <= '0;
      db_cnt    <= '0;
      o_Level   <= 1'b0;
      level_d   <= 1'b0;
      state_q   <= R_IDLE;
      timer_q   <= '0;
      o_Pulse   <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], i_Raw};
      if (sync_pipe[1] == o_Level) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        o_Level <= sync_pipe[1];
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
      level_d <= o_Level;
      state_q <= state_d;
      timer_q <= timer_d;
      o_Pulse <= pulse_d;
    end
  end

  // i_Hold is the combo FSM's next-state decode, so strobes are masked in
  // every cycle that o_Combo_Active is high.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    if (i_Hold || fall) begin
      state_d = R_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          timer_d = '0;
          if (rise) begin
            pulse_d = 1'b1;
            state_d = R_DELAY;
          end
        end
        R_DELAY: begin
          if (timer_q == TW'(REPEAT_DELAY - 1)) begin
            pulse_d = 1'b1;
            state_d = R_REPEAT;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        R_REPEAT: begin
          if (timer_q == TW'(REPEAT_RATE - 1)) begin
            pulse_d = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = R_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end
endmodule

module switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 3750000,
  parameter int START_HOLD      = 2500000,
  parameter int COMBO_HOLD      = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [3:0] o_Switch_Level,
  output logic [3:0] o_Move_Pulse,
  output logic       o_Start_Pulse,
  output logic       o_Reset_Pulse,
  output logic       o_Combo_Active
);
  localparam int NUM_LANES = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_T = max2(max2(max2(REPEAT_DELAY, REPEAT_RATE),
                                   max2(START_HOLD, COMBO_HOLD)), DEBOUNCE_CYCLES);
  localparam int TW    = ($clog2(MAX_T) < 1) ? 1 : $clog2(MAX_T);

  typedef enum logic [1:0] {C_IDLE, C_START, C_RESET, C_LATCH} combo_state_t;

  logic [NUM_LANES-1:0] raw;
  combo_state_t         c_q, c_d;
  logic [TW-1:0]        ct_q, ct_d;
  logic                 start_d, reset_d, combo_hold;

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    switch_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .TW             (TW)
    ) u_lane (
      .i_Clk  (i_Clk),
      .i_Reset(i_Reset),
      .i_Raw  (raw[g]),
      .i_Hold (combo_hold),
      .o_Level(o_Switch_Level[g]),
      .o_Pulse(o_Move_Pulse[g])
    );
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      c_q            <= C_IDLE;
      ct_q           <= '0;
      o_Start_Pulse  <= 1'b0;
      o_Reset_Pulse  <= 1'b0;
      o_Combo_Active <= 1'b0;
    end else begin
      c_q            <= c_d;
      ct_q           <= ct_d;
      o_Start_Pulse  <= start_d;
      o_Reset_Pulse  <= reset_d;
      o_Combo_Active <= combo_hold;
    end
  end

  always_comb begin
    c_d     = c_q;
    ct_d    = ct_q;
    start_d = 1'b0;
    reset_d = 1'b0;
    case (c_q)
      C_IDLE: begin
        ct_d = '0;
        if (o_Switch_Level == 4'b1111)      c_d = C_RESET;
        else if (o_Switch_Level == 4'b0111) c_d = C_START;
      end
      C_START: begin
        if (o_Switch_Level == 4'b1111) begin
          c_d  = C_RESET;
          ct_d = '0;
        end else if (o_Switch_Level != 4'b0111) begin
          c_d  = C_IDLE;
          ct_d = '0;
        end else if (ct_q == TW'(START_HOLD - 1)) begin
          start_d = 1'b1;
          c_d     = C_LATCH;
          ct_d    = '0;
        end else begin
          ct_d = ct_q + TW'(1);
        end
      end
      C_RESET: begin
        if (o_Switch_Level != 4'b1111) begin
          c_d  = C_IDLE;
          ct_d = '0;
        end else if (ct_q == TW'(COMBO_HOLD - 1)) begin
          reset_d = 1'b1;
          c_d     = C_LATCH;
          ct_d    = '0;
        end else begin
          ct_d = ct_q + TW'(1);
        end
      end
      C_LATCH: begin
        ct_d = '0;
        if (o_Switch_Level == 4'b0000) c_d = C_IDLE;
      end
      default: begin
        c_d  = C_IDLE;
        ct_d = '0;
      end
    endcase
    combo_hold = (c_d != C_IDLE);
  end
endmodule

// File: tb/tb_switch_conditioner.sv
// Randomised + directed bench for switch_conditioner: a timestamp-based
// reference model queues expected output events; a monitor pops and compares.

module tb_switch_conditioner;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 5;
  localparam int SH = 8;
  localparam int CH = 16;

  localparam int M_NONE  = 0;
  localparam int M_START = 1;
  localparam int M_RESET = 2;
  localparam int M_LATCH = 3;

  typedef struct packed {
    logic [3:0] lvl;
    logic [3:0] mv;
    logic       st;
    logic       rs;
    logic       act;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } ev_t;

  logic       i_Clk, i_Reset;
  logic       i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4;
  logic [3:0] o_Switch_Level, o_Move_Pulse;
  logic       o_Start_Pulse, o_Reset_Pulse, o_Combo_Active;

  switch_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .START_HOLD     (SH),
    .COMBO_HOLD     (CH)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_Switch_1    (i_Switch_1),
    .i_Switch_2    (i_Switch_2),
    .i_Switch_3    (i_Switch_3),
    .i_Switch_4    (i_Switch_4),
    .o_Switch_Level(o_Switch_Level),
    .o_Move_Pulse  (o_Move_Pulse),
    .o_Start_Pulse (o_Start_Pulse),
    .o_Reset_Pulse (o_Reset_Pulse),
    .o_Combo_Active(o_Combo_Active)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  bit  mon_en = 0;
  ev_t q[$];

  // Reference model state
  logic [3:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_lvlp = '0;
  int   m_run [4] = '{0, 0, 0, 0};
  bit   m_alive [4] = '{0, 0, 0, 0};
  int   m_first [4] = '{0, 0, 0, 0};
  int   m_mode = M_NONE;
  int   m_since = 0;
  obs_t m_prev = '0;

  // Monitor observations
  obs_t dut_prev = '0;
  int   rise_cyc [4] = '{-1, -1, -1, -1};
  int   mv_cyc [4] = '{-1, -1, -1, -1};
  int   n_start = 0, n_reset = 0, n_1001 = 0;

  always @(posedge i_Clk) begin
    obs_t       e;
    logic [3:0] raw, nl;
    int         age;
    ev_t        ev;
    cyc++;
    raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
    e = '0;
    if (i_Reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvlp = '0;
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_alive[i] = 0;
      end
      m_mode = M_NONE;
    end else begin
      case (m_mode)
        M_NONE: begin
          if (m_lvl == 4'b1111) begin m_mode = M_RESET; m_since = cyc; end
          else if (m_lvl == 4'b0111) begin m_mode = M_START; m_since = cyc; end
        end
        M_START: begin
          if (m_lvl == 4'b1111) begin m_mode = M_RESET; m_since = cyc; end
          else if (m_lvl != 4'b0111) m_mode = M_NONE;
          else if (cyc - m_since == SH) begin e.st = 1'b1; m_mode = M_LATCH; end
        end
        M_RESET: begin
          if (m_lvl != 4'b1111) m_mode = M_NONE;
          else if (cyc - m_since == CH) begin e.rs = 1'b1; m_mode = M_LATCH; end
        end
        default: if (m_lvl == 4'b0000) m_mode = M_NONE;
      endcase
      e.act = (m_mode != M_NONE);
      for (int i = 0; i < 4; i++) begin
        if (e.act || (!m_lvl[i] && m_lvlp[i])) m_alive[i] = 0;
        else if (m_lvl[i] && !m_lvlp[i]) begin m_alive[i] = 1; m_first[i] = cyc; end
        if (m_alive[i]) begin
          age = cyc - m_first[i];
          if (age == 0 || age == RD || (age > RD && (age - RD) % RR == 0)) e.mv[i] = 1'b1;
        end
      end
      nl = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin nl[i] = m_s2[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1; m_s1 = raw;
      m_lvlp = m_lvl; m_lvl = nl;
      e.lvl = nl;
    end
    if (e != m_prev || (|e.mv) || e.st || e.rs) begin
      ev.cyc = cyc; ev.o = e;
      q.push_back(ev);
    end
    m_prev = e;
  end

  always @(negedge i_Clk) begin
    obs_t d;
    ev_t  ev;
    if (mon_en) begin
      d = {o_Switch_Level, o_Move_Pulse, o_Start_Pulse, o_Reset_Pulse, o_Combo_Active};
      for (int i = 0; i < 4; i++) begin
        if (d.lvl[i] && !dut_prev.lvl[i]) rise_cyc[i] = cyc;
        if (d.mv[i]) mv_cyc[i] = cyc;
      end
      if (d.mv == 4'b1001) n_1001++;
      if (d.st) n_start++;
      if (d.rs) n_reset++;
      if (d !== dut_prev || (|d.mv) || d.st || d.rs) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected cyc=%0d got=%h", cyc, d);
        end else begin
          ev = q.pop_front();
          if (ev.cyc != cyc || ev.o !== d) begin
            fails++;
            $display("FAIL sb_event got cyc=%0d obs=%h required cyc=%0d obs=%h", cyc, d, ev.cyc, ev.o);
          end
        end
      end
      dut_prev = d;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = v;
    repeat (n) @(negedge i_Clk);
  endtask

  initial begin
    int         t0, s0, r0, p0;
    logic [3:0] v;
    int         n, sel;
    i_Reset = 1'b1;
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = 4'b0000;
    repeat (3) @(negedge i_Clk);
    i_Reset = 1'b0;
    check("rst_level",  32'(o_Switch_Level), 0);
    check("rst_move",   32'(o_Move_Pulse), 0);
    check("rst_start",  32'(o_Start_Pulse), 0);
    check("rst_reset",  32'(o_Reset_Pulse), 0);
    check("rst_active", 32'(o_Combo_Active), 0);
    mon_en = 1;
    drive(4'b0000, 5);

    // Bounce on Switch_1, then a clean rise
    for (int k = 0; k < 5; k++) begin
      drive(4'b0001, 2);
      drive(4'b0000, 2);
    end
    t0 = cyc;
    drive(4'b0001, 9);
    check("bounce_level_rise", rise_cyc[0] - t0, 6);
    check("bounce_first_move", mv_cyc[0] - t0, 7);
    drive(4'b0001, 11);
    drive(4'b0000, 12);

    // Hold-repeat on Switch_2
    drive(4'b0010, 46);
    drive(4'b0000, 12);

    // Start combo
    s0 = n_start; r0 = n_reset;
    drive(4'b0111, 26);
    drive(4'b0000, 14);
    check("start_once", n_start - s0, 1);
    check("start_no_reset", n_reset - r0, 0);

    // Reset combo
    s0 = n_start; r0 = n_reset;
    drive(4'b1111, 30);
    drive(4'b0000, 14);
    check("reset_once", n_reset - r0, 1);
    check("reset_no_start", n_start - s0, 0);

    // Reset combo aborted by releasing Switch_4, falls back to start combo
    s0 = n_start; r0 = n_reset;
    drive(4'b1111, 12);
    drive(4'b0111, 30);
    drive(4'b0000, 14);
    check("abort_no_reset", n_reset - r0, 0);
    check("abort_start", n_start - s0, 1);

    // Mid-operation reset while Switch_3 repeats
    drive(4'b0100, 24);
    i_Reset = 1'b1;
    @(negedge i_Clk);
    check("midrst_outputs", 32'({o_Switch_Level, o_Move_Pulse, o_Start_Pulse,
                                 o_Reset_Pulse, o_Combo_Active}), 0);
    i_Reset = 1'b0;
    t0 = cyc;
    drive(4'b0100, 15);
    check("midrst_rerise", rise_cyc[2] - t0, 6);
    check("midrst_move", mv_cyc[2] - t0, 7);
    drive(4'b0000, 12);

    // Simultaneous Switch_1 and Switch_4
    p0 = n_1001;
    drive(4'b1001, 8);
    drive(4'b0000, 12);
    check("simul_1001", n_1001 - p0, 1);

    // Randomised segments, biased toward the combo patterns
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0) v = 4'b0111;
      else if (sel == 1) v = 4'b1111;
      else v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) n = $urandom_range(1, 3);
      else n = $urandom_range(6, 45);
      if ($urandom_range(0, 19) == 0) begin
        i_Reset = 1'b1;
        @(negedge i_Clk);
        i_Reset = 1'b0;
      end
      drive(v, n);
    end

    drive(4'b0000, 40);
    check("sb_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
